mc_ctrl: RTL and testbench

Multi-cycle MIPS control unit. It sequences the shared datapath (PC, unified memory port, IR, register file, single ALU) through fetch, decode, execute, memory and write-back steps. It replaces the combinational control of the single-cycle core. It adds a memory wait-state handshake and an illegal-opcode trap pulse.

---
 rtl/mc_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mc_ctrl                                                       |
// | Purpose  : Multi-cycle MIPS control unit. Sequences the shared datapath  |
// |            (PC, unified memory port, IR, register file, single ALU)      |
// |            through fetch / decode / execute / memory / write-back.       |
// |            Handles memory wait states, traps undecoded instructions and  |
// |            recovers from stalled memory accesses with a timeout.         |
// | Ports    : clk, rst_n (async, active low)                                |
// |            opcode/funct  - IR fields, zero - ALU zero flag               |
// |            mem_ready     - memory access completes this cycle            |
// |            pc_en..pc_src - datapath control strobes and mux selects      |
// |            state         - current FSM state (debug)                     |
// |            illegal       - 1-cycle pulse on undecoded opcode/funct       |
// |            err_timeout   - 1-cycle pulse on memory timeout               |
// |            cycle_cnt / instret_cnt - performance counters                |
// | Params   : FETCH_TIMEOUT - wait-cycle limit in memory states (0 = off)   |
// | Macros   : PERF_CNT_EN   - build the cycle / retired-instr counters;     |
// |                           when undefined both counter ports read 0.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mc_ctrl #(
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        zext,
  output logic [2:0]  alu_ctrl,
  output logic [1:0]  pc_src,
  output logic [3:0]  state,
  output logic        illegal,
  output logic        err_timeout,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BR       = 4'd8,
    S_JMP      = 4'd9,
    S_I_EX     = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;

  localparam logic [7:0] TIMEOUT_LIM = 8'(FETCH_TIMEOUT);
  localparam bit         TIMEOUT_EN  = (FETCH_TIMEOUT != 0);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Strobes that must be suppressed while reset is asserted.
  logic pc_en_c, ir_write_c, reg_write_c, mem_rd_c, mem_wr_c, illegal_c;
  logic mem_wait;   // in a memory state and the access has not completed
  logic tmo;        // wait limit reached this cycle with no completion

  logic       r_funct_ok;
  logic [2:0] r_alu;

  // R-type funct decode, shared by DECODE (legality) and R_EX (ALU op).
  always_comb begin
    r_funct_ok = 1'b1;
    r_alu      = ALU_ADD;
    case (funct)
      6'h20:   r_alu = ALU_ADD;
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h27:   r_alu = ALU_NOR;
      6'h2A:   r_alu = ALU_SLT;
      default: begin
        r_funct_ok = 1'b0;
        r_alu      = ALU_AND;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_en_c     = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_rd_c    = 1'b0;
    mem_wr_c    = 1'b0;
    illegal_c   = 1'b0;
    mem_wait    = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    zext        = 1'b0;
    alu_ctrl    = 3'b000;
    pc_src      = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_rd_c  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_en_c    = 1'b1;
          state_d    = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        // ALU computes PC + (imm << 2) now so BR can use ALUOut.
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_RTYPE: begin
            if (r_funct_ok) begin
              state_d = S_R_EX;
            end else begin
              illegal_c = 1'b1;
              state_d   = S_FETCH;
            end
          end
          OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                     state_d = S_BR;
          OP_J:                               state_d = S_JMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_d = S_I_EX;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_rd_c = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
        else           mem_wait = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wr_c = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
        else           mem_wait = 1'b1;
      end
      S_R_EX: begin
        alu_src_a = 1'b1;
        alu_ctrl  = r_alu;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
        state_d     = S_FETCH;
      end
      S_I_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_SLTI: alu_ctrl = ALU_SLT;
          OP_ANDI: begin
            alu_ctrl = ALU_AND;
            zext     = 1'b1;
          end
          OP_ORI: begin
            alu_ctrl = ALU_OR;
            zext     = 1'b1;
          end
          default: alu_ctrl = ALU_ADD;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BR: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        // beq branches on equal operands, bne on unequal.
        pc_en_c   = zero ^ (opcode == OP_BNE);
        state_d   = S_FETCH;
      end
      S_JMP: begin
        pc_src  = 2'b10;
        pc_en_c = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Only a cycle without completion can time out, so mem_ready always wins.
    tmo = TIMEOUT_EN && mem_wait && (wait_cnt_q == TIMEOUT_LIM);
    if (tmo) state_d = S_FETCH;

    // A FETCH timeout keeps the state, so the clear must be explicit.
    if (tmo || (state_d != state_q)) wait_cnt_d = 8'd0;
    else if (mem_wait)               wait_cnt_d = wait_cnt_q + 8'd1;
    else                             wait_cnt_d = wait_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign state       = state_q;
  assign pc_en       = rst_n & pc_en_c;
  assign ir_write    = rst_n & ir_write_c;
  assign reg_write   = rst_n & reg_write_c;
  assign mem_rd      = rst_n & mem_rd_c;
  assign mem_wr      = rst_n & mem_wr_c;
  assign illegal     = rst_n & illegal_c;
  assign err_timeout = rst_n & tmo;

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;

  // An instruction retires when control returns to FETCH normally;
  // trap and timeout returns do not count.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + 32'd1;
    instret_cnt_d = instret_cnt_q;
    if ((state_q != S_FETCH) && (state_d == S_FETCH) && !illegal_c && !tmo)
      instret_cnt_d = instret_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mc_ctrl                                                    |
// | Purpose  : Self-checking bench for mc_ctrl (FETCH_TIMEOUT = 4).          |
// |            Per-cycle vector table of {inputs, expected state, expected   |
// |            control word}, plus hand sequences for reset and counters.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_en, iord, mem_rd, mem_wr, ir_write, reg_dst, mem_to_reg;
  logic        reg_write, alu_src_a, zext, illegal, err_timeout;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  mc_ctrl #(.FETCH_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .zext(zext), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
    .state(state), .illegal(illegal), .err_timeout(err_timeout),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  typedef struct packed {
    logic       pc_en, iord, mem_rd, mem_wr, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       zext;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       illegal, err_timeout;
  } ctl_t;

  typedef struct {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] exp_state;
    ctl_t       exp_ctl;
  } vec_t;

  ctl_t act_ctl;
  assign act_ctl = {pc_en, iord, mem_rd, mem_wr, ir_write, reg_dst, mem_to_reg, reg_write,
                    alu_src_a, alu_src_b, zext, alu_ctrl, pc_src, illegal, err_timeout};

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ncyc;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---- expected control words, written from the state descriptions ----
  function automatic ctl_t c_fetch(input logic rdy, input logic to);
    ctl_t c = '0;
    c.mem_rd = 1'b1; c.alu_src_b = 2'b01; c.alu_ctrl = 3'b010;
    c.ir_write = rdy; c.pc_en = rdy; c.err_timeout = to;
    return c;
  endfunction
  function automatic ctl_t c_reset();
    ctl_t c = '0;
    c.alu_src_b = 2'b01; c.alu_ctrl = 3'b010;
    return c;
  endfunction
  function automatic ctl_t c_decode(input logic ill);
    ctl_t c = '0;
    c.alu_src_b = 2'b11; c.alu_ctrl = 3'b010; c.illegal = ill;
    return c;
  endfunction
  function automatic ctl_t c_maddr();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010;
    return c;
  endfunction
  function automatic ctl_t c_mrd(input logic to);
    ctl_t c = '0;
    c.mem_rd = 1'b1; c.iord = 1'b1; c.err_timeout = to;
    return c;
  endfunction
  function automatic ctl_t c_mwb();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_mwr();
    ctl_t c = '0;
    c.mem_wr = 1'b1; c.iord = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_rex(input logic [2:0] alu);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_ctrl = alu;
    return c;
  endfunction
  function automatic ctl_t c_rwb();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.reg_dst = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_iex(input logic [2:0] alu, input logic zx);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = alu; c.zext = zx;
    return c;
  endfunction
  function automatic ctl_t c_iwb();
    ctl_t c = '0;
    c.reg_write = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_br(input logic taken);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_ctrl = 3'b110; c.pc_src = 2'b01; c.pc_en = taken;
    return c;
  endfunction
  function automatic ctl_t c_jmp();
    ctl_t c = '0;
    c.pc_src = 2'b10; c.pc_en = 1'b1;
    return c;
  endfunction

  task automatic av(input logic [5:0] op, input logic [5:0] fn, input logic z,
                    input logic rdy, input logic [3:0] st, input ctl_t c);
    vec_t v;
    v.opcode = op; v.funct = fn; v.zero = z; v.mem_ready = rdy;
    v.exp_state = st; v.exp_ctl = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  logic [5:0] rfn  [6];
  logic [2:0] ralu [6];
  logic [5:0] iop  [4];
  logic [2:0] ialu [4];
  logic       izx  [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rfn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    ralu = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b100, 3'b111};
    iop  = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
    ialu = '{3'b010, 3'b111, 3'b000, 3'b001};
    izx  = '{1'b0, 1'b0, 1'b1, 1'b1};

    // R-type: FETCH, DECODE, R_EX, R_WB (mem_ready toggled in R_EX: ignored)
    for (int i = 0; i < 6; i++) begin
      av(6'h00, rfn[i], 1'b0, 1'b1, 4'd0, c_fetch(1'b1, 1'b0));
      av(6'h00, rfn[i], 1'b0, 1'b0, 4'd1, c_decode(1'b0));
      av(6'h00, rfn[i], 1'b0, 1'(i % 2), 4'd6, c_rex(ralu[i]));
      av(6'h00, rfn[i], 1'b0, 1'b0, 4'd7, c_rwb());
    end
    // I-type
    for (int i = 0; i < 4; i++) begin
      av(iop[i], 6'h3F, 1'b0, 1'b1, 4'd0, c_fetch(1'b1, 1'b0));
      av(iop[i], 6'h3F, 1'b0, 1'b0, 4'd1, c_decode(1'b0));
      av(iop[i], 6'h3F, 1'b0, 1'b0, 4'd10, c_iex(ialu[i], izx[i]));
      av(iop[i], 6'h3F, 1'b0, 1'b1, 4'd11, c_iwb());
    end
    // lw with 3 wait states: 8 cycles, mem_rd/iord held 4 cycles in MEM_RD
    av(6'h23, 6'h00, 1'b0, 1'b1, 4'd0, c_fetch(1'b1, 1'b0));
    av(6'h23, 6'h00, 1'b0, 1'b0, 4'd1, c_decode(1'b0));
    av(6'h23, 6'h00, 1'b0, 1'b0, 4'd2, c_maddr());
    for (int i = 0; i < 3; i++) av(6'h23, 6'h00, 1'b0, 1'b0, 4'd3, c_mrd(1'b0));
    av(6'h23, 6'h00, 1'b0, 1'b1, 4'd3, c_mrd(1'b0));
    av(6'h23, 6'h00, 1'b0, 1'b0, 4'd4, c_mwb());
    // sw: mem_ready arrives exactly in the timeout cycle -> completes, no error
    av(6'h2B, 6'h00, 1'b0, 1'b1, 4'd0, c_fetch(1'b1, 1'b0));
    av(6'h2B, 6'h00, 1'b0, 1'b0, 4'd1, c_decode(1'b0));
    av(6'h2B, 6'h00, 1'b0, 1'b0, 4'd2, c_maddr());
    for (int i = 0; i < 4; i++) av(6'h2B, 6'h00, 1'b0, 1'b0, 4'd5, c_mwr());
    av(6'h2B, 6'h00, 1'b0, 1'b1, 4'd5, c_mwr());
    // beq zero=1 with two FETCH wait states, then taken
    av(6'h04, 6'h00, 1'b1, 1'b0, 4'd0, c_fetch(1'b0, 1'b0));
    av(6'h04, 6'h00, 1'b1, 1'b0, 4'd0, c_fetch(1'b0, 1'b0));
    av(6'h04, 6'h00, 1'b1, 1'b1, 4'd0, c_fetch(1'b1, 1'b0));
    av(6'h04, 6'h00, 1'b1, 1'b0, 4'd1, c_decode(1'b0));
    av(6'h04, 6'h00, 1'b1, 1'b0, 4'd8, c_br(1'b1));
    // beq zero=0, bne zero=1, bne zero=0
    for (int i = 0; i < 3; i++) begin
      logic [5:0] op;
      logic       z, tk;
      op = (i == 0) ? 6'h04 : 6'h05;
      z  = (i == 1);
      tk = (i == 2);
      av(op, 6'h00, z, 1'b1, 4'd0, c_fetch(1'b1, 1'b0));
      av(op, 6'h00, z, 1'b0, 4'd1, c_decode(1'b0));
      av(op, 6'h00, z, 1'b0, 4'd8, c_br(tk));
    end
    // j
    av(6'h02, 6'h00, 1'b0, 1'b1, 4'd0, c_fetch(1'b1, 1'b0));
    av(6'h02, 6'h00, 1'b0, 1'b0, 4'd1, c_decode(1'b0));
    av(6'h02, 6'h00, 1'b0, 1'b1, 4'd9, c_jmp());
    // illegal opcode 0x3F, then R-type with funct 0x01
    av(6'h3F, 6'h20, 1'b0, 1'b1, 4'd0, c_fetch(1'b1, 1'b0));
    av(6'h3F, 6'h20, 1'b0, 1'b0, 4'd1, c_decode(1'b1));
    av(6'h00, 6'h01, 1'b0, 1'b1, 4'd0, c_fetch(1'b1, 1'b0));
    av(6'h00, 6'h01, 1'b0, 1'b0, 4'd1, c_decode(1'b1));
    // lw whose read never completes: timeout on the 5th MEM_RD cycle
    av(6'h23, 6'h00, 1'b0, 1'b1, 4'd0, c_fetch(1'b1, 1'b0));
    av(6'h23, 6'h00, 1'b0, 1'b0, 4'd1, c_decode(1'b0));
    av(6'h23, 6'h00, 1'b0, 1'b0, 4'd2, c_maddr());
    for (int i = 0; i < 4; i++) av(6'h23, 6'h00, 1'b0, 1'b0, 4'd3, c_mrd(1'b0));
    av(6'h23, 6'h00, 1'b0, 1'b0, 4'd3, c_mrd(1'b1));
    // FETCH stalled: two timeouts, then completion in the timeout cycle
    for (int k = 0; k < 14; k++)
      av(6'h02, 6'h00, 1'b0, 1'b0, 4'd0, c_fetch(1'b0, 1'((k % 5) == 4)));
    av(6'h02, 6'h00, 1'b0, 1'b1, 4'd0, c_fetch(1'b1, 1'b0));
    av(6'h02, 6'h00, 1'b0, 1'b0, 4'd1, c_decode(1'b0));
    av(6'h02, 6'h00, 1'b0, 1'b0, 4'd9, c_jmp());

    // ---- power-on reset ----
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    ncyc = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_ctl", 64'(act_ctl), 64'(c_reset()));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- vector table ----
    for (int i = 0; i < tbl.size(); i++) begin
      opcode = tbl[i].opcode; funct = tbl[i].funct;
      zero = tbl[i].zero; mem_ready = tbl[i].mem_ready;
      @(negedge clk);
      chk($sformatf("vec%0d{state,ctl}", i), 64'({state, act_ctl}),
          64'({tbl[i].exp_state, tbl[i].exp_ctl}));
      next_cycle();
    end

    // ---- reset in the middle of MEM_RD ----
    opcode = 6'h23; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    next_cycle();                 // -> DECODE
    mem_ready = 1'b0;
    next_cycle();                 // -> MEM_ADDR
    next_cycle();                 // -> MEM_RD
    @(negedge clk);
    chk("pre_reset_in_mem_rd", 64'({state, mem_rd, iord}), 64'({4'd3, 1'b1, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_state", 64'(state), 64'd0);
    chk("async_reset_mem_rd", 64'(mem_rd), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("held_reset_ctl", 64'({state, act_ctl}), 64'({4'd0, c_reset()}));
    rst_n = 1'b1;

    // ---- FETCH stuck for 10 cycles: timeouts, counters ----
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("post_reset_fetch", 64'({state, act_ctl}), 64'({4'd0, c_fetch(1'b0, 1'b0)}));
        chk("post_reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
      end
      chk($sformatf("stall%0d_err_timeout", k), 64'({state, err_timeout}),
          64'({4'd0, 1'((k % 5) == 4)}));
      @(posedge clk); #1;
    end
    mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20;
    @(negedge clk);
    chk("stall_cycle_cnt", 64'(cycle_cnt), PERF ? 64'd10 : 64'd0);
    chk("stall_instret_cnt", 64'(instret_cnt), 64'd0);

    // add retires one instruction
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("add_state", 64'(state), 64'd0);
    chk("add_instret_cnt", 64'(instret_cnt), PERF ? 64'd1 : 64'd0);
    chk("add_cycle_cnt", 64'(cycle_cnt), PERF ? 64'd14 : 64'd0);

    // illegal opcode does not retire
    opcode = 6'h3F; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ill_instret_cnt", 64'(instret_cnt), PERF ? 64'd1 : 64'd0);
    chk("ill_cycle_cnt", 64'(cycle_cnt), PERF ? 64'd16 : 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
